instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream fetch stage for the single-cycle CPU core.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions, with their PCs, in a small prefetch queue. The decode stage consumes the queue through a valid/ready interface.
- Branch/jump redirects from the core flush the queue and restart fetch at the target.

Parameters:
- DEPTH, 4: prefetch queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset; word aligned.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word address of the request; bits [1:0] always 0.
- imem_ack  in  1  request accepted, and imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- halt  in  1  when high, no new request is issued; a pending request still completes.
- redirect_valid  in  1  one-cycle pulse: flush and restart fetch.
- redirect_target  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  decode accepts the head.
- inst_data  out  32  queue-head instruction.
- inst_pc  out  32  PC of the queue-head instruction.
- perf_fetched  out  32  count of instructions pushed (optional feature).
- perf_discarded  out  32  count of discarded responses (optional feature).

Behaviour:
- Reset values: imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, queue empty, inst_valid=0, inst_data=0, inst_pc=0, perf counters=0, state=IDLE.
- Reset asserted mid-transaction abandons any pending request. The memory must tolerate the request being dropped.

State machine (states: IDLE, WAIT, WAIT_DISCARD):
- IDLE:
  - Issue condition: !halt, !redirect_valid, and (count + 1) <= DEPTH, where count is the occupancy after this cycle's pop.
  - When the condition holds, next cycle imem_req=1, imem_addr=fetch_pc, and the state moves to WAIT.
- WAIT:
  - imem_req and imem_addr are held stable until imem_ack. Ack may arrive in the first req cycle, giving minimum latency of 1 cycle from issue to push.
  - On ack: push {fetch_pc, imem_rdata}, fetch_pc += 4, and go to IDLE.
- WAIT_DISCARD:
  - Entered when redirect_valid arrives while in WAIT without ack.
  - Request stays held. On ack the data is dropped, perf_discarded increments, and the state goes to IDLE.
- Back-to-back issue: from IDLE, a new request may be issued the cycle after an ack, so sustained throughput is 1 instruction per 2 cycles.

Only one request is outstanding at a time. The space check counts that outstanding request, so the queue never overflows.

Redirect:
- Sets fetch_pc to {redirect_target[31:2],2'b00}.
- Flushes the queue in the same cycle, so inst_valid=0 next cycle.
- A same-cycle pop is void.
- Redirect in the same cycle as ack: redirect wins, data is discarded and counted, state goes to IDLE.
- Redirect in IDLE: no request is issued that cycle.

Queue:
- Output is first-word-fall-through: inst_* reflect the head combinationally from queue storage.
- Pop on inst_valid && inst_ready.
- Push and pop in the same cycle are legal at any occupancy, including full-with-pop.

Other rules:
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- halt does not block redirect or pop.

Optional Feature:
FETCH_PERF_EN
- Defined: perf_fetched increments on every push and perf_discarded on every dropped ack. Both are 32-bit, wrap at 2^32, and are cleared by reset.
- Undefined: no counter logic is built; both ports are tied to 0. The port list is unchanged.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, WAIT, WAIT_DISCARD}
  - PC_STEP=4
  - INST_W=32
  - typedef fetch_entry_t {pc[31:0], inst[31:0]}
- One sub-module, fetch_queue:
  - synchronous FIFO of fetch_entry_t with flush, push, pop, count, empty, full.
  - Flush has priority over push and pop.

Test Plan:
- Reset, inst_ready=1, memory acks same cycle with rdata=addr^32'hA5A5_0000 → imem_addr 0,4,8,… and inst_pc/inst_data pairs match in order, one push every 2 cycles.
- inst_ready=0 with DEPTH=4 → exactly 4 entries pushed, imem_req stays 0 afterwards; raise inst_ready → fetch resumes at 0x10 with no gap or duplicate.
- Ack delayed 3 cycles, redirect to 0x0000_0103 in the 2nd wait cycle → response dropped (perf_discarded=1 with FETCH_PERF_EN), next imem_addr=0x0000_0100, queue empty until its ack.
- Redirect in the same cycle as ack and pop with 2 entries queued → inst_valid=0 next cycle, no push, next request at the target.
- redirect_target=32'hFFFF_FFFC → PCs FFFF_FFFC then 0000_0000.
- halt=1 while in WAIT → pending ack is pushed, no further imem_req until halt=0; a redirect during halt still flushes the queue.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, queue entry layout, PC step.
// No logic of its own; imported by fetch_queue and instr_fetch_unit.
// Entry width is pc + inst, carried as one packed struct through the queue.
package fetch_pkg;

    localparam int          INST_W  = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT         = 2'd1,
        WAIT_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch_entry_t with first-word-fall-through head and flush.
// Latency: push visible at head the next cycle; head is combinational from storage.
// Backpressure: push ignored when full without a same-cycle pop; flush beats push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_dat_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // Full-with-pop may push: the slot being written is the one the head vacates.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem read at a time, responses queued with their PCs for decode.
// Latency: issue->push >= 1 cycle, 1 instr / 2 cycles sustained; optional FETCH_PERF_EN adds counters.
// Backpressure: no issue unless the queue has room after this cycle's pop; redirect flushes and restarts.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_discarded
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      addr_q, addr_d;
    logic             req_q, req_d;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] cnt_after_pop;
    logic             q_empty;
    logic             q_full;
    logic             pop;
    logic             push;
    logic             discard;
    logic             can_issue;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic             unused_bits;

    assign redirect_pc = {redirect_target[31:2], 2'b00};
    assign unused_bits = ^{redirect_target[1:0], q_full, discard};

    assign inst_valid    = !q_empty;
    assign pop           = inst_valid && inst_ready && !redirect_valid;
    assign cnt_after_pop = q_count - CNT_W'(pop);
    // Only IDLE issues, so nothing is in flight when the room check is made.
    assign can_issue     = !halt && !redirect_valid && (cnt_after_pop < CNT_W'(DEPTH));

    assign push    = (state_q == WAIT) && imem_ack && !redirect_valid;
    assign discard = imem_ack && ((state_q == WAIT_DISCARD) ||
                                  ((state_q == WAIT) && redirect_valid));

    assign push_entry.pc   = addr_q;
    assign push_entry.inst = imem_rdata;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        unique case (state_q)
            IDLE: begin
                if (can_issue) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    req_d      = 1'b0;
                    state_d    = IDLE;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                end else if (redirect_valid) begin
                    state_d = WAIT_DISCARD;
                end
            end
            WAIT_DISCARD: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (redirect_valid),
        .push_i     (push),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (q_count),
        .empty_o    (q_empty),
        .full_o     (q_full)
    );

    assign inst_data = head.inst;
    assign inst_pc   = head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] discarded_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q   <= '0;
            discarded_q <= '0;
        end else begin
            if (push) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (discard) begin
                discarded_q <= discarded_q + 32'd1;
            end
        end
    end

    assign perf_fetched   = fetched_q;
    assign perf_discarded = discarded_q;
`else
    assign perf_fetched   = '0;
    assign perf_discarded = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model acks after a programmable delay,
// rdata = addr ^ 32'hA5A5_0000; decode pops are logged for ordering checks.
module tb_instr_fetch_unit;

`ifdef FETCH_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] perf_fetched;
    logic [31:0] perf_discarded;

    int n_total = 0;
    int n_bad   = 0;
    int ack_dly = 0;
    int wcnt    = 0;
    logic [31:0] pop_pc[$];
    logic [31:0] pop_dat[$];
    logic [31:0] ack_addr[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .halt            (halt),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .perf_fetched    (perf_fetched),
        .perf_discarded  (perf_discarded)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // One clock: drive the memory response for this cycle, log handshakes, advance.
    task automatic tick();
        logic req_was;
        req_was = imem_req;
        if (imem_req && wcnt >= ack_dly) begin
            imem_ack   = 1'b1;
            imem_rdata = rdat(imem_addr);
            ack_addr.push_back(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = '0;
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
            pop_pc.push_back(inst_pc);
            pop_dat.push_back(inst_data);
        end
        @(posedge clk);
        #1;
        if (imem_ack || !req_was) wcnt = 0;
        else wcnt++;
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        halt = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        wcnt = 0;
        pop_pc.delete();
        pop_dat.delete();
        ack_addr.delete();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && !inst_valid; i++) tick();
        chk(tag, {31'd0, inst_valid}, 32'd1);
    endtask

    initial begin
        // Reset state
        inst_ready = 1'b1;
        ack_dly = 0;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_pf", perf_fetched, 32'h0);
        chk("rst_pd", perf_discarded, 32'h0);
        reset = 1'b0;

        // Streaming: same-cycle ack, one push every two cycles
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s_req", {31'd0, imem_req}, 32'd1);
            chk("s_addr", imem_addr, 32'(4 * k));
            chk("s_empty", {31'd0, inst_valid}, 32'd0);
            tick();
            chk("s_valid", {31'd0, inst_valid}, 32'd1);
            chk("s_pc", inst_pc, 32'(4 * k));
            chk("s_data", inst_data, rdat(32'(4 * k)));
            chk("s_reqlow", {31'd0, imem_req}, 32'd0);
        end
        chk("s_perf", perf_fetched, PERF_ON ? 32'd4 : 32'd0);

        // Backpressure: queue fills to DEPTH, then resumes at 0x10
        inst_ready = 1'b0;
        do_reset();
        repeat (20) tick();
        chk("bp_acks", 32'(ack_addr.size()), 32'd4);
        chk("bp_req", {31'd0, imem_req}, 32'd0);
        chk("bp_head", inst_pc, 32'h0);
        inst_ready = 1'b1;
        for (int i = 0; i < 40 && pop_pc.size() < 6; i++) tick();
        chk("bp_npop", 32'(pop_pc.size()), 32'd6);
        for (int i = 0; i < 6 && i < pop_pc.size(); i++) begin
            chk("bp_pc", pop_pc[i], 32'(4 * i));
            chk("bp_dat", pop_dat[i], rdat(32'(4 * i)));
        end
        chk("bp_resume", ack_addr[4], 32'h10);

        // Redirect while waiting on a slow ack
        ack_dly = 3;
        do_reset();
        tick();
        chk("rd_req", {31'd0, imem_req}, 32'd1);
        tick();
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        chk("rd_hold_req", {31'd0, imem_req}, 32'd1);
        chk("rd_hold_addr", imem_addr, 32'h0);
        tick();
        chk("rd_empty0", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("rd_idle", {31'd0, imem_req}, 32'd0);
        chk("rd_empty1", {31'd0, inst_valid}, 32'd0);
        chk("rd_pd", perf_discarded, PERF_ON ? 32'd1 : 32'd0);
        chk("rd_pf", perf_fetched, 32'd0);
        tick();
        chk("rd_tgt_req", {31'd0, imem_req}, 32'd1);
        chk("rd_tgt_addr", imem_addr, 32'h0000_0100);
        repeat (3) tick();
        chk("rd_empty2", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("rd_valid", {31'd0, inst_valid}, 32'd1);
        chk("rd_pc", inst_pc, 32'h0000_0100);
        chk("rd_data", inst_data, rdat(32'h0000_0100));

        // Redirect coinciding with ack and pop, two entries queued
        ack_dly = 0;
        inst_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        chk("ra_req", {31'd0, imem_req}, 32'd1);
        chk("ra_addr", imem_addr, 32'h8);
        chk("ra_head", inst_pc, 32'h0);
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("ra_flush", {31'd0, inst_valid}, 32'd0);
        chk("ra_reqlow", {31'd0, imem_req}, 32'd0);
        chk("ra_pd", perf_discarded, PERF_ON ? 32'd1 : 32'd0);
        chk("ra_pf", perf_fetched, PERF_ON ? 32'd2 : 32'd0);
        tick();
        chk("ra_tgt", imem_addr, 32'h0000_0200);
        chk("ra_tgt_req", {31'd0, imem_req}, 32'd1);
        tick();
        chk("ra_pc", inst_pc, 32'h0000_0200);

        // PC wrap at 2^32, redirect while IDLE
        do_reset();
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wr_noissue", {31'd0, imem_req}, 32'd0);
        tick();
        chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wr_pc0", inst_pc, 32'hFFFF_FFFC);
        chk("wr_dat0", inst_data, 32'h5A5A_FFFC);
        tick();
        chk("wr_addr1", imem_addr, 32'h0);
        chk("wr_req1", {31'd0, imem_req}, 32'd1);
        tick();
        chk("wr_pc1", inst_pc, 32'h0);
        chk("wr_dat1", inst_data, 32'hA5A5_0000);

        // Halt during WAIT: pending ack still lands, nothing new issued
        ack_dly = 2;
        inst_ready = 1'b0;
        do_reset();
        tick();
        chk("h_req", {31'd0, imem_req}, 32'd1);
        halt = 1'b1;
        wait_valid("h_push_timeout", 10);
        chk("h_pc", inst_pc, 32'h0);
        repeat (4) tick();
        chk("h_noreq", {31'd0, imem_req}, 32'd0);
        chk("h_nacks", 32'(ack_addr.size()), 32'd1);
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        chk("h_flush", {31'd0, inst_valid}, 32'd0);
        repeat (3) tick();
        chk("h_noreq2", {31'd0, imem_req}, 32'd0);
        halt = 1'b0;
        tick();
        chk("h_resume_req", {31'd0, imem_req}, 32'd1);
        chk("h_resume_addr", imem_addr, 32'h0000_0040);

        // Reset abandons an outstanding request
        ack_dly = 100;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ra_rst_req", {31'd0, imem_req}, 32'd0);
        chk("ra_rst_addr", imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
